// File: rtl/ps2_key_tracker_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared constants, state encoding and helpers for the PS/2
//                set-2 key tracker and its history buffer.
//  Revision    : 1.0  initial release
// ============================================================================
package ps2_pkg;

    // Set-2 protocol bytes
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_ERR0  = 8'h00;
    localparam logic [7:0] SC_ERR1  = 8'hFF;

    // Sequence tracker states, one-hot
    typedef enum logic [3:0] {
        ST_IDLE    = 4'b0001,
        ST_EXT     = 4'b0010,
        ST_BRK     = 4'b0100,
        ST_BRK_EXT = 4'b1000
    } state_e;

    // 00 and FF are keyboard error/overrun codes, never valid key codes
    function automatic logic is_err_code(input logic [7:0] b);
        return (b == SC_ERR0) || (b == SC_ERR1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_key_hist.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_key_hist
//  Description : Circular history of the most recent DEPTH pushed entries
//                with an age-indexed combinational read port.
//  Ports       : clk, rst (async active-low)
//                push_i  - write data_i at the write pointer
//                data_i  - entry to store
//                idx_i   - age select, 0 = most recent push
//                data_o  - selected entry, 0 if not yet written
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_key_hist #(
    parameter int DEPTH = 4,
    parameter int W     = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [W-1:0]             data_i,
    input  logic [$clog2(DEPTH)-1:0] idx_i,
    output logic [W-1:0]             data_o
);

    localparam int IW = $clog2(DEPTH);
    localparam logic [IW:0] FULL = (IW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [IW-1:0] wptr_q;
    logic [IW:0]   count_q;

    logic [IW-1:0] rd_ptr;
    logic          rd_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            count_q <= '0;
        end else if (push_i) begin
            mem_q[wptr_q] <= data_i;
            wptr_q        <= wptr_q + IW'(1);
            if (count_q != FULL) begin
                count_q <= count_q + (IW+1)'(1);
            end
        end
    end

    // DEPTH is a power of two, so the pointer arithmetic wraps by itself
    always_comb begin
        rd_ptr   = wptr_q - IW'(1) - idx_i;
        rd_valid = ({1'b0, idx_i} < count_q);
        data_o   = rd_valid ? mem_q[rd_ptr] : '0;
    end

endmodule
`default_nettype wire

// File: rtl/ps2_key_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_key_tracker
//  Description : Tracks PS/2 set-2 make / break / extended sequences from
//                decoded bytes. Produces held-key state, press / repeat /
//                release pulses, a wrapping press counter, a history of
//                recent presses and a stalled-sequence timeout.
//  Ports       : clk, rst (async active-low)
//                ps2_data/ps2_valid - received byte and its strobe
//                cnt_clr            - synchronous clear of press_cnt
//                hist_idx           - history age select
//                key_code/key_ext/key_down - last pressed key and held flag
//                press_pulse/repeat_pulse/release_pulse/seq_err - pulses
//                rel_code           - {ext, code} of last release
//                press_cnt          - press count modulo 2^CNT_W
//                hist_code          - {ext, code} of selected history entry
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int HIST_DEPTH = 4,
    parameter int TIMEOUT    = 1000000,
    parameter bit EXT_EN     = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    ps2_data,
    input  logic                          ps2_valid,
    input  logic                          cnt_clr,
    input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
    output logic [7:0]                    key_code,
    output logic                          key_ext,
    output logic                          key_down,
    output logic                          press_pulse,
    output logic                          repeat_pulse,
    output logic                          release_pulse,
    output logic [8:0]                    rel_code,
    output logic                          seq_err,
    output logic [CNT_W-1:0]              press_cnt,
    output logic [8:0]                    hist_code
);

    localparam int              TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_e            state_q,   state_d;
    logic [TO_W-1:0]   to_q,      to_d;
    logic [7:0]        code_q,    code_d;
    logic              ext_q,     ext_d;
    logic              down_q,    down_d;
    logic              press_q,   press_d;
    logic              rep_q,     rep_d;
    logic              rel_q,     rel_d;
    logic [8:0]        relc_q,    relc_d;
    logic              err_q,     err_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;

    // Decoded action for the current byte
    logic              do_press;
    logic              do_release;
    logic              act_ext;
    logic              same_key;
    logic              hist_push;

    // ------------------------------------------------------------------
    // Sequence FSM: next state and action decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        to_d       = to_q;
        err_d      = 1'b0;
        do_press   = 1'b0;
        do_release = 1'b0;
        act_ext    = 1'b0;

        if (ps2_valid) begin
            // Any byte restarts the stall timer, including one landing on
            // the expiry cycle.
            to_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (ps2_data == SC_BREAK) begin
                        state_d = ST_BRK;
                    end else if (EXT_EN && (ps2_data == SC_EXT)) begin
                        state_d = ST_EXT;
                    end else if (is_err_code(ps2_data)) begin
                        err_d = 1'b1;
                    end else begin
                        do_press = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (ps2_data == SC_BREAK) begin
                        state_d = ST_BRK_EXT;
                    end else if (ps2_data == SC_EXT) begin
                        // Repeated E0 prefix is harmless
                        state_d = ST_EXT;
                    end else if (is_err_code(ps2_data)) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        do_press = 1'b1;
                        act_ext  = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
                ST_BRK, ST_BRK_EXT: begin
                    state_d = ST_IDLE;
                    if (is_err_code(ps2_data) || (ps2_data == SC_BREAK) ||
                        (ps2_data == SC_EXT)) begin
                        err_d = 1'b1;
                    end else begin
                        do_release = 1'b1;
                        act_ext    = (state_q == ST_BRK_EXT);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if (state_q != ST_IDLE) begin
            if (to_q == TO_LAST) begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
                to_d    = '0;
            end else begin
                to_d = to_q + TO_W'(1);
            end
        end else begin
            to_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // Key state, pulses and counter
    // ------------------------------------------------------------------
    always_comb begin
        code_d    = code_q;
        ext_d     = ext_q;
        down_d    = down_q;
        press_d   = 1'b0;
        rep_d     = 1'b0;
        rel_d     = 1'b0;
        relc_d    = relc_q;
        cnt_d     = cnt_q;
        hist_push = 1'b0;

        same_key = ({ext_q, code_q} == {act_ext, ps2_data});

        if (do_press) begin
            if (down_q && same_key) begin
                // Typematic repeat of the held key: no count, no history
                rep_d = 1'b1;
            end else begin
                code_d    = ps2_data;
                ext_d     = act_ext;
                down_d    = 1'b1;
                press_d   = 1'b1;
                hist_push = 1'b1;
                cnt_d     = cnt_q + CNT_W'(1);
            end
        end

        if (do_release) begin
            rel_d  = 1'b1;
            relc_d = {act_ext, ps2_data};
            // Releasing some other key leaves the held key untouched
            if (same_key) begin
                down_d = 1'b0;
            end
        end

        if (cnt_clr) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            to_q    <= '0;
            code_q  <= '0;
            ext_q   <= 1'b0;
            down_q  <= 1'b0;
            press_q <= 1'b0;
            rep_q   <= 1'b0;
            rel_q   <= 1'b0;
            relc_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            to_q    <= to_d;
            code_q  <= code_d;
            ext_q   <= ext_d;
            down_q  <= down_d;
            press_q <= press_d;
            rep_q   <= rep_d;
            rel_q   <= rel_d;
            relc_q  <= relc_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Press history
    // ------------------------------------------------------------------
    ps2_key_hist #(
        .DEPTH (HIST_DEPTH),
        .W     (9)
    ) u_hist (
        .clk    (clk),
        .rst    (rst),
        .push_i (hist_push),
        .data_i ({act_ext, ps2_data}),
        .idx_i  (hist_idx),
        .data_o (hist_code)
    );

    assign key_code      = code_q;
    assign key_ext       = ext_q;
    assign key_down      = down_q;
    assign press_pulse   = press_q;
    assign repeat_pulse  = rep_q;
    assign release_pulse = rel_q;
    assign rel_code      = relc_q;
    assign seq_err       = err_q;
    assign press_cnt     = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_key_tracker
//  Description : Self-checking bench for ps2_key_tracker. Two instances run
//                side by side (extended prefix enabled / disabled) against a
//                prefix-flag reference model with a shift-array history.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ps2_key_tracker;

    localparam int HD = 4;
    localparam int TO = 16;
    localparam int CW = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ps2_data;
    logic       ps2_valid;
    logic       cnt_clr;
    logic [1:0] hist_idx;

    logic [7:0]    key_code      [2];
    logic          key_ext       [2];
    logic          key_down      [2];
    logic          press_pulse   [2];
    logic          repeat_pulse  [2];
    logic          release_pulse [2];
    logic [8:0]    rel_code      [2];
    logic          seq_err       [2];
    logic [CW-1:0] press_cnt     [2];
    logic [8:0]    hist_code     [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ps2_key_tracker #(.CNT_W(CW), .HIST_DEPTH(HD), .TIMEOUT(TO), .EXT_EN(1'b1)) u_dut (
        .clk(clk), .rst(rst), .ps2_data(ps2_data), .ps2_valid(ps2_valid),
        .cnt_clr(cnt_clr), .hist_idx(hist_idx),
        .key_code(key_code[0]), .key_ext(key_ext[0]), .key_down(key_down[0]),
        .press_pulse(press_pulse[0]), .repeat_pulse(repeat_pulse[0]),
        .release_pulse(release_pulse[0]), .rel_code(rel_code[0]),
        .seq_err(seq_err[0]), .press_cnt(press_cnt[0]), .hist_code(hist_code[0])
    );

    ps2_key_tracker #(.CNT_W(CW), .HIST_DEPTH(HD), .TIMEOUT(TO), .EXT_EN(1'b0)) u_dut_noext (
        .clk(clk), .rst(rst), .ps2_data(ps2_data), .ps2_valid(ps2_valid),
        .cnt_clr(cnt_clr), .hist_idx(hist_idx),
        .key_code(key_code[1]), .key_ext(key_ext[1]), .key_down(key_down[1]),
        .press_pulse(press_pulse[1]), .repeat_pulse(repeat_pulse[1]),
        .release_pulse(release_pulse[1]), .rel_code(rel_code[1]),
        .seq_err(seq_err[1]), .press_cnt(press_cnt[1]), .hist_code(hist_code[1])
    );

    // ---------------- reference model (index 0: E0 enabled, 1: disabled)
    bit         m_e0   [2];
    bit         m_f0   [2];
    int         m_idle [2];
    logic [7:0] m_code [2];
    bit         m_ext  [2];
    bit         m_down [2];
    bit         m_pp   [2];
    bit         m_rp   [2];
    bit         m_rl   [2];
    bit         m_err  [2];
    logic [8:0] m_rel  [2];
    int         m_cnt  [2];
    logic [8:0] m_hist [2][HD];
    int         m_hn   [2];

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            m_e0[i] = 0; m_f0[i] = 0; m_idle[i] = 0; m_code[i] = '0;
            m_ext[i] = 0; m_down[i] = 0; m_pp[i] = 0; m_rp[i] = 0;
            m_rl[i] = 0; m_err[i] = 0; m_rel[i] = '0; m_cnt[i] = 0; m_hn[i] = 0;
            for (int k = 0; k < HD; k++) m_hist[i][k] = '0;
        end
    endtask

    task automatic m_press(input int i, input logic [7:0] b, input bit e);
        if (m_down[i] && m_ext[i] == e && m_code[i] == b) begin
            m_rp[i] = 1;
        end else begin
            m_code[i] = b; m_ext[i] = e; m_down[i] = 1; m_pp[i] = 1;
            m_cnt[i] = (m_cnt[i] + 1) % (1 << CW);
            for (int k = HD - 1; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
            m_hist[i][0] = {e, b};
            if (m_hn[i] < HD) m_hn[i]++;
        end
    endtask

    task automatic m_release(input int i, input logic [7:0] b, input bit e);
        m_rl[i]  = 1;
        m_rel[i] = {e, b};
        if (m_ext[i] == e && m_code[i] == b) m_down[i] = 0;
    endtask

    task automatic m_step(input int i, input bit v, input logic [7:0] d, input bit clr);
        bit junk;
        junk = (d == 8'h00) || (d == 8'hFF);
        m_pp[i] = 0; m_rp[i] = 0; m_rl[i] = 0; m_err[i] = 0;
        if (v) begin
            m_idle[i] = 0;
            if (m_f0[i]) begin
                if (junk || d == 8'hE0 || d == 8'hF0) m_err[i] = 1;
                else m_release(i, d, m_e0[i]);
                m_e0[i] = 0; m_f0[i] = 0;
            end else if (m_e0[i]) begin
                if (d == 8'hF0) m_f0[i] = 1;
                else if (d == 8'hE0) m_e0[i] = 1;
                else if (junk) begin m_err[i] = 1; m_e0[i] = 0; end
                else begin m_press(i, d, 1'b1); m_e0[i] = 0; end
            end else begin
                if (d == 8'hF0) m_f0[i] = 1;
                else if (d == 8'hE0 && i == 0) m_e0[i] = 1;
                else if (junk) m_err[i] = 1;
                else m_press(i, d, 1'b0);
            end
        end else if (m_e0[i] || m_f0[i]) begin
            m_idle[i]++;
            if (m_idle[i] == TO) begin
                m_err[i] = 1; m_e0[i] = 0; m_f0[i] = 0; m_idle[i] = 0;
            end
        end
        if (clr) m_cnt[i] = 0;
    endtask

    // ---------------- checking
    task automatic chk(input string tag, input int i, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s inst%0d observed=%h expected=%h t=%0t", tag, i, got, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [8:0] eh;
        for (int i = 0; i < 2; i++) begin
            eh = (int'(hist_idx) < m_hn[i]) ? m_hist[i][hist_idx] : 9'h000;
            chk("key_code", i, 32'(key_code[i]), 32'(m_code[i]));
            chk("key_ext",  i, 32'(key_ext[i]),  32'(m_ext[i]));
            chk("key_down", i, 32'(key_down[i]), 32'(m_down[i]));
            chk("press",    i, 32'(press_pulse[i]), 32'(m_pp[i]));
            chk("repeat",   i, 32'(repeat_pulse[i]), 32'(m_rp[i]));
            chk("release",  i, 32'(release_pulse[i]), 32'(m_rl[i]));
            chk("rel_code", i, 32'(rel_code[i]), 32'(m_rel[i]));
            chk("seq_err",  i, 32'(seq_err[i]), 32'(m_err[i]));
            chk("press_cnt", i, 32'(press_cnt[i]), 32'(m_cnt[i]));
            chk("hist_code", i, 32'(hist_code[i]), 32'(eh));
        end
    endtask

    // One clock: inputs applied at the falling edge, outputs checked at the next one
    task automatic cyc(input bit v, input logic [7:0] d, input bit clr);
        ps2_valid = v;
        ps2_data  = v ? d : 8'($urandom);
        cnt_clr   = clr;
        hist_idx  = 2'($urandom);
        for (int i = 0; i < 2; i++) m_step(i, v, d, clr);
        @(posedge clk);
        @(negedge clk);
        ps2_valid = 1'b0;
        cnt_clr   = 1'b0;
        check_all();
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b0;
        ps2_valid = 1'b0;
        cnt_clr = 1'b0;
        m_reset();
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic read_hist(input logic [1:0] idx, input logic [8:0] exp);
        hist_idx = idx;
        #1;
        chk("hist_read", 0, 32'(hist_code[0]), 32'(exp));
    endtask

    function automatic logic [7:0] pick_byte();
        case ($urandom_range(0, 11))
            0:       return 8'hF0;
            1, 2:    return 8'hE0;
            3:       return 8'h00;
            4:       return 8'hFF;
            5, 6:    return 8'h1C;
            7, 8:    return 8'h75;
            9:       return 8'h2C;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        rst = 1'b0; ps2_valid = 1'b0; ps2_data = '0; cnt_clr = 1'b0; hist_idx = '0;
        m_reset();
        #1;
        check_all();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // make then break
        cyc(1, 8'h1C, 0);
        chk("plan_press", 0, 32'(press_pulse[0]), 32'd1);
        chk("plan_code",  0, 32'(key_code[0]), 32'h1C);
        chk("plan_cnt",   0, 32'(press_cnt[0]), 32'd1);
        cyc(1, 8'hF0, 0);
        cyc(1, 8'h1C, 0);
        chk("plan_rel",   0, 32'(rel_code[0]), 32'h01C);
        chk("plan_down",  0, 32'(key_down[0]), 32'd0);

        // typematic repeat
        do_reset();
        cyc(1, 8'h1C, 0);
        cyc(1, 8'h1C, 0);
        chk("plan_rep", 0, 32'(repeat_pulse[0]), 32'd1);
        cyc(1, 8'h1C, 0);
        chk("plan_rep_cnt", 0, 32'(press_cnt[0]), 32'd1);
        read_hist(2'd0, 9'h01C);
        read_hist(2'd1, 9'h000);

        // extended make and break, and E0 as a plain key when disabled
        do_reset();
        cyc(1, 8'hE0, 0);
        cyc(1, 8'h75, 0);
        chk("plan_ext", 0, 32'(key_ext[0]), 32'd1);
        chk("plan_noext_cnt", 1, 32'(press_cnt[1]), 32'd2);
        cyc(1, 8'hE0, 0);
        cyc(1, 8'hF0, 0);
        cyc(1, 8'h75, 0);
        chk("plan_ext_rel", 0, 32'(rel_code[0]), 32'h175);
        chk("plan_noext_code", 1, 32'(key_code[1]), 32'hE0);
        chk("plan_noext_down", 1, 32'(key_down[1]), 32'd1);

        // history wrap
        do_reset();
        cyc(1, 8'h15, 0); cyc(1, 8'h1D, 0); cyc(1, 8'h24, 0);
        cyc(1, 8'h2D, 0); cyc(1, 8'h2C, 0);
        read_hist(2'd0, 9'h02C);
        read_hist(2'd1, 9'h02D);
        read_hist(2'd2, 9'h024);
        read_hist(2'd3, 9'h01D);
        chk("plan_cnt5", 0, 32'(press_cnt[0]), 32'd5);

        // timeout after a lone break prefix
        do_reset();
        cyc(1, 8'hF0, 0);
        for (int k = 1; k < TO; k++) cyc(0, 8'h00, 0);
        chk("plan_to_early", 0, 32'(seq_err[0]), 32'd0);
        cyc(0, 8'h00, 0);
        chk("plan_to", 0, 32'(seq_err[0]), 32'd1);
        cyc(1, 8'h1C, 0);
        chk("plan_to_press", 0, 32'(press_pulse[0]), 32'd1);

        // malformed break, clear priority, reset mid-sequence
        do_reset();
        cyc(1, 8'hF0, 0);
        cyc(1, 8'hF0, 0);
        chk("plan_ff_err", 0, 32'(seq_err[0]), 32'd1);
        chk("plan_ff_rel", 0, 32'(release_pulse[0]), 32'd0);
        cyc(1, 8'h1C, 1);
        chk("plan_clr", 0, 32'(press_cnt[0]), 32'd0);
        cyc(1, 8'hE0, 0);
        cyc(1, 8'hF0, 0);
        do_reset();
        cyc(1, 8'h1C, 0);
        chk("plan_rst_press", 0, 32'(press_pulse[0]), 32'd1);

        // randomized traffic with idle gaps long enough to expire
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else if ($urandom_range(0, 29) == 0) begin
                for (int g = $urandom_range(1, TO + 4); g > 0; g--) cyc(0, 8'h00, 0);
            end else begin
                cyc($urandom_range(0, 2) != 0, pick_byte(), $urandom_range(0, 31) == 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
- Parametrised successor to the team's make/break scancode FSM. Consumes decoded PS/2 bytes (one-cycle valid pulses from the PS/2 receiver) and tracks set-2 sequences: make, break (F0), extended (E0) and extended break (E0 F0).
- Produces held-key state, press/release/repeat pulses and a wrapping press counter.
- Keeps a history buffer of the last HIST_DEPTH pressed keys for the display logic.
- Aborts stalled sequences with a timeout.

Parameters:
- CNT_W, 8, press counter width.
- HIST_DEPTH, 4, history entries; power of two, at least 2.
- TIMEOUT, 1000000, idle cycles in a non-IDLE state before the sequence aborts.
- EXT_EN, 1, when 0 an E0 byte is treated as an ordinary make code.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- ps2_data  in  8  received byte; sampled only when ps2_valid=1.
- ps2_valid  in  1  one-cycle strobe per received byte.
- cnt_clr  in  1  synchronous clear of press_cnt.
- hist_idx  in  $clog2(HIST_DEPTH)  history age select; 0 = most recent.
- key_code  out  8  code of the last pressed key.
- key_ext  out  1  last pressed key was extended.
- key_down  out  1  last pressed key is still held.
- press_pulse  out  1  one cycle per new press (repeats excluded).
- repeat_pulse  out  1  one cycle per typematic repeat of the held key.
- release_pulse  out  1  one cycle per completed break sequence.
- rel_code  out  9  {ext, code} of the last release.
- seq_err  out  1  one-cycle pulse on malformed sequence or timeout.
- press_cnt  out  CNT_W  number of presses, modulo 2^CNT_W.
- hist_code  out  9  {ext, code} of history entry hist_idx; 0 if that entry is not yet valid.

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs, history storage, history count and timeout counter are 0.
- FSM states: IDLE, EXT, BRK, BRK_EXT. Transitions occur only on ps2_valid. All pulses are registered, one cycle after the byte.
- IDLE:
  - F0 -> BRK.
  - E0 with EXT_EN=1 -> EXT.
  - 00 or FF -> seq_err; stay IDLE.
  - Any other byte b -> press(b, 0).
- EXT:
  - F0 -> BRK_EXT.
  - E0 -> stay in EXT, no error.
  - 00 or FF -> seq_err, IDLE.
  - Other b -> press(b, 1), IDLE.
- BRK / BRK_EXT:
  - E0, F0, 00 or FF -> seq_err, IDLE; no release.
  - Other b -> release(b, ext), IDLE. ext=0 from BRK, 1 from BRK_EXT.
- press(b, e):
  - If key_down=1 and {key_ext, key_code}={e, b}: repeat_pulse only. No count, no history push.
  - Otherwise: key_code<=b, key_ext<=e, key_down<=1, press_pulse, press_cnt+1 (wraps to 0), push {e, b} into history.
- release(b, e): release_pulse; rel_code<={e, b}. key_down<=0 only if {e, b} matches {key_ext, key_code}; otherwise key_down is unchanged.
- cnt_clr: takes priority over a same-cycle increment; press_cnt becomes 0.
- History:
  - Circular buffer; write pointer advances on each push; valid-entry count saturates at HIST_DEPTH.
  - The oldest entry is overwritten when full.
  - hist_code is a combinational read of entry (wptr-1-hist_idx) mod HIST_DEPTH.
- Timeout:
  - Counter is 0 in IDLE and reloads to 0 on every ps2_valid.
  - Increments in a non-IDLE state without a byte.
  - On reaching TIMEOUT: seq_err, state=IDLE, counter=0.
  - A byte arriving in the expiry cycle is processed normally; no timeout fires.
- Reset mid-sequence: any partial prefix is discarded.

Decomposition:
- Shared package ps2_pkg: constants SC_BREAK=8'hF0, SC_EXT=8'hE0, SC_ERR0=8'h00, SC_ERR1=8'hFF; state encoding (one-hot, 4 bits).
- Sub-module ps2_key_hist (HIST_DEPTH, 9-bit entries): push, valid-count and age-indexed read.

Test Plan:
- 1C, F0, 1C -> press_pulse, key_code=1C, key_ext=0, press_cnt=1; then release_pulse, rel_code=01C, key_down=0.
- 1C, 1C, 1C (held) -> one press_pulse and two repeat_pulse; press_cnt=1; history holds one entry, hist_code(0)=01C.
- E0, 75, E0, F0, 75 -> key_ext=1, key_code=75, press_cnt+1; release rel_code=175, key_down=0. With EXT_EN=0 the E0 counts as a press of code E0.
- Presses 15, 1D, 24, 2D, 2C with HIST_DEPTH=4 -> hist_idx 0..3 reads 02C, 02D, 024, 01D; press_cnt=5.
- F0 then no byte for TIMEOUT cycles (TIMEOUT=16 in the bench) -> seq_err pulse at cycle 16, state IDLE. A following 1C is a press, not a release.
- F0, F0 -> seq_err, no release_pulse. cnt_clr in the same cycle as a press -> press_cnt=0. Reset mid E0 F0 -> all outputs 0, next 1C is a press.
